// File: rtl/pe_pkg.sv
// Shared PE-array definitions: instruction/algorithm encodings, legal packing
// widths and the coefficient packer state type.
package pe_pkg;

  typedef enum logic [3:0] {
    PE_NOP    = 4'd0,
    PE_NTT    = 4'd1,
    PE_INTT   = 4'd2,
    PE_PWM    = 4'd3,
    PE_ADD    = 4'd4,
    PE_SUB    = 4'd5,
    PE_CMP_1  = 4'd6,
    PE_CMP_4  = 4'd7,
    PE_CMP_5  = 4'd8,
    PE_CMP_10 = 4'd9,
    PE_CMP_11 = 4'd10,
    PE_DCMP   = 4'd11
  } pe_instr_t;

  typedef enum logic [1:0] {
    ALG_MLKEM = 2'd0,
    ALG_MLDSA = 2'd1
  } pe_alg_t;

  localparam logic [3:0] D_1  = 4'd1;
  localparam logic [3:0] D_4  = 4'd4;
  localparam logic [3:0] D_5  = 4'd5;
  localparam logic [3:0] D_10 = 4'd10;
  localparam logic [3:0] D_11 = 4'd11;
  localparam logic [3:0] D_12 = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pack_state_t;

  // Anything outside the compress/plain widths packs as full 12-bit coefficients.
  function automatic logic [3:0] d_legal(input logic [3:0] d);
    case (d)
      D_1, D_4, D_5, D_10, D_11, D_12: return d;
      default:                         return D_12;
    endcase
  endfunction

endpackage

// File: rtl/coef_packer_if.sv
// Coefficient-in / packed-word-out handshake bundle for coef_packer.
interface coef_packer_if #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32,
  parameter int OUT_W = 32
);

  logic                       in_valid;
  logic                       in_ready;
  logic [NUM-1:0][WIDTH-1:0]  in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_data;
  logic                       out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/coef_lane_merge.sv
// Concatenates the low d bits of each lane, lane 0 at bit 0 (ByteEncode_d order).
module coef_lane_merge #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32
) (
  input  logic [NUM-1:0][WIDTH-1:0] in_data,
  input  logic [3:0]                d,
  output logic [NUM*12-1:0]         p
);

  localparam int PW = NUM * 12;

  logic [11:0] mask;

  assign mask = 12'((13'd1 << d) - 13'd1);

  always_comb begin
    p = '0;
    for (int k = 0; k < NUM; k++) begin
      p = p | (PW'(in_data[k][11:0] & mask) << (k * int'(d)));
    end
  end

endmodule

// File: rtl/coef_packer.sv
// Bit packer: NUM lanes of d-bit coefficients into OUT_W-bit words, zero-padded flush.
// Optional sticky lane range check enabled by COEF_PACKER_RANGE_CHK_EN.
module coef_packer
  import pe_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int WIDTH = 32,
  parameter int OUT_W = 32,
  parameter int BUF_W = 96
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          d_sel,
  coef_packer_if.slave        bus,
  output logic                busy,
  output logic                range_err
);

  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int PW    = NUM * 12;

  pack_state_t       state, state_nxt;
  logic [BUF_W-1:0]  bit_buf, buf_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_pop;
  logic [CNT_W-1:0]  beat_bits, pop_bits;
  logic [3:0]        d_reg, d_eff;
  logic [PW-1:0]     p;
  logic              push, pop;

  // In IDLE the first beat must already pack with the width being latched.
  assign d_eff     = (state == IDLE) ? d_legal(d_sel) : d_reg;
  assign beat_bits = CNT_W'(NUM * int'(d_eff));

  coef_lane_merge #(
    .NUM   (NUM),
    .WIDTH (WIDTH)
  ) u_merge (
    .in_data (bus.in_data),
    .d       (d_eff),
    .p       (p)
  );

  assign bus.out_valid = (cnt >= CNT_W'(OUT_W)) || ((state == FLUSH) && (cnt != '0));
  assign bus.out_last  = (state == FLUSH) && (cnt <= CNT_W'(OUT_W));
  assign bus.out_data  = bit_buf[OUT_W-1:0];

  assign pop      = bus.out_valid && bus.out_ready;
  assign pop_bits = !pop ? '0 : (bus.out_last ? cnt : CNT_W'(OUT_W));
  assign cnt_pop  = cnt - pop_bits;

  // Room is judged after this cycle's pop, so in_ready depends on out_ready.
  assign bus.in_ready = rst && (state != FLUSH) &&
                        ((int'(cnt_pop) + int'(beat_bits)) <= BUF_W);
  assign push = bus.in_valid && bus.in_ready;

  assign buf_nxt = (bit_buf >> pop_bits) | (push ? (BUF_W'(p) << cnt_pop) : '0);
  assign cnt_nxt = cnt_pop + (push ? beat_bits : '0);

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = bus.in_last ? FLUSH : RUN;
      RUN:     if (push && bus.in_last) state_nxt = FLUSH;
      FLUSH:   if ((pop && bus.out_last) || (cnt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_buf <= '0;
      cnt     <= '0;
      d_reg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_buf <= buf_nxt;
      cnt     <= cnt_nxt;
      if (state == IDLE) d_reg <= d_legal(d_sel);
    end
  end

`ifdef COEF_PACKER_RANGE_CHK_EN
  logic lane_over;

  always_comb begin
    lane_over = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      if ((bus.in_data[k] >> d_eff) != '0) lane_over = 1'b1;
    end
  end

  // Sticky for the whole polynomial; cleared as the packer returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      range_err <= 1'b0;
    end else if ((state == FLUSH) && (state_nxt == IDLE)) begin
      range_err <= 1'b0;
    end else if (push && lane_over) begin
      range_err <= 1'b1;
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_coef_packer.sv
// Randomized bench for coef_packer against a bitstream-level ByteEncode_d model.
module tb_coef_packer;

  localparam int NUM   = 4;
  localparam int WIDTH = 32;
  localparam int OUT_W = 32;
  localparam int BUF_W = 96;

  typedef logic [NUM-1:0][WIDTH-1:0] beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_sel;
  logic       busy;
  logic       range_err;

  coef_packer_if #(.NUM(NUM), .WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

  coef_packer #(
    .NUM   (NUM),
    .WIDTH (WIDTH),
    .OUT_W (OUT_W),
    .BUF_W (BUF_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_sel     (d_sel),
    .bus       (bus.slave),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  beat_t       beats[$];
  logic [31:0] got_w[$];
  int          nrdy_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_rand(input int n, input bit full);
    beats.delete();
    for (int i = 0; i < n; i++) begin
      beat_t b;
      for (int k = 0; k < NUM; k++) b[k] = full ? $urandom : ($urandom & 32'hFFF);
      beats.push_back(b);
    end
  endtask

  function automatic int legal_d(input int d);
    if (d == 1 || d == 4 || d == 5 || d == 10 || d == 11 || d == 12) return d;
    return 12;
  endfunction

  task automatic run_poly(input int d, input int stall_lo, input int stall_hi,
                          input bit rnd_stall, input int abort_at);
    bit          q[$];
    logic [31:0] exp_w[$];
    logic [31:0] w, held_w;
    int          ed, nb, nw, bi, wi, occ, pbits, cyc;
    bit          exp_rerr, seen, done, held, exp_rdy;

    ed = legal_d(d);
    nb = beats.size();
    exp_rerr = 0;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < NUM; k++) begin
        for (int b = 0; b < ed; b++) q.push_back(beats[i][k][b]);
        if ((beats[i][k] >> ed) != 0) exp_rerr = 1;
      end
`ifndef COEF_PACKER_RANGE_CHK_EN
    exp_rerr = 0;
`endif
    nw = (q.size() + 31) / 32;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int b = 0; b < 32; b++) if (i * 32 + b < q.size()) w[b] = q[i * 32 + b];
      exp_w.push_back(w);
    end

    got_w.delete();
    nrdy_cnt = 0;
    d_sel = 4'(d);
    bi = 0; wi = 0; occ = 0; cyc = 0;
    seen = 0; done = 0; held = 0; held_w = '0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      bus.out_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc < stall_hi);
      if (bi < nb) begin
        bus.in_valid = 1'b1;
        bus.in_data  = beats[bi];
        bus.in_last  = (bi == nb - 1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
      end
      #1;
      if (abort_at > 0 && cyc == abort_at) return;
      if (held) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, held_w);
      end
      pbits = 0;
      if (bus.out_valid && bus.out_ready) begin
        got_w.push_back(bus.out_data);
        if (wi < nw) begin
          chk("word", bus.out_data, exp_w[wi]);
          chk("last", bus.out_last, wi == nw - 1);
          pbits = (wi == nw - 1) ? occ : 32;
          if (wi == nw - 1) done = 1;
        end else begin
          chk("extra_word", wi, nw);
          done = 1;
        end
        wi++;
      end
      if (bi < nb) begin
        exp_rdy = (occ - pbits + NUM * ed) <= BUF_W;
        chk("in_ready", bus.in_ready, exp_rdy);
        if (!bus.in_ready) nrdy_cnt++;
      end
      if (bus.in_valid && bus.in_ready) begin
        occ += NUM * ed;
        bi++;
      end
      occ -= pbits;
      held   = bus.out_valid && !bus.out_ready;
      held_w = bus.out_data;
      if (range_err) seen = 1;
      cyc++;
    end
    chk("finished", done, 1'b1);
    chk("word_count", wi, nw);
    chk("range_seen", seen, exp_rerr);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", bus.out_valid, 1'b0);
    chk("idle_rerr", range_err, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_out_valid"}, bus.out_valid, 1'b0);
    chk({pfx, "_out_data"}, bus.out_data, 32'h0);
    chk({pfx, "_out_last"}, bus.out_last, 1'b0);
    chk({pfx, "_in_ready"}, bus.in_ready, 1'b0);
    chk({pfx, "_busy"}, busy, 1'b0);
    chk({pfx, "_range_err"}, range_err, 1'b0);
  endtask

  initial begin
    int dl[6];
    dl = '{1, 4, 5, 10, 11, 12};
    rst = 1'b0;
    d_sel = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    #2;
    chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // d=1 alternating lanes -> one full word
    beats.delete();
    for (int i = 0; i < 8; i++) beats.push_back({32'd0, 32'd1, 32'd0, 32'd1});
    run_poly(1, 0, 0, 0, 0);
    chk("t1_count", got_w.size(), 1);
    chk("t1_word", got_w.size() > 0 ? got_w[0] : 32'h0, 32'h55555555);

    // d=12 single beat -> two words
    beats.delete();
    beats.push_back({32'h789, 32'h456, 32'h123, 32'hABC});
    run_poly(12, 0, 0, 0, 0);
    chk("t2_count", got_w.size(), 2);
    chk("t2_word0", got_w.size() > 0 ? got_w[0] : 32'h0, 32'h56123ABC);
    chk("t2_word1", got_w.size() > 1 ? got_w[1] : 32'h0, 32'h00007894);

    // d=10 full polynomial, full-width random data exercises truncation
    fill_rand(64, 1'b1);
    run_poly(10, 0, 0, 0, 0);
    chk("t3_count", got_w.size(), 80);

    // d=11 with a 10-cycle output stall
    fill_rand(64, 1'b0);
    run_poly(11, 20, 30, 0, 0);
    chk("t4_count", got_w.size(), 88);
    chk("t4_backpressure", nrdy_cnt > 0, 1'b1);

    // reset in the middle of a d=5 polynomial, then a fresh one
    fill_rand(64, 1'b0);
    run_poly(5, 0, 0, 0, 15);
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fill_rand(16, 1'b0);
    run_poly(5, 0, 0, 0, 0);
    chk("t5_count", got_w.size(), 10);

    // d=4 out-of-range lane is truncated to its low nibble
    beats.delete();
    beats.push_back({32'h4, 32'h3, 32'h2, 32'h1F});
    run_poly(4, 0, 0, 0, 0);
    chk("t6_word", got_w.size() > 0 ? got_w[0] : 32'h0, 32'h0000432F);

    // illegal width packs as 12 bits
    fill_rand(3, 1'b0);
    run_poly(7, 0, 0, 0, 0);
    chk("t7_count", got_w.size(), 5);

    // random widths, lengths and output stalls
    for (int t = 0; t < 6; t++) begin
      fill_rand($urandom_range(1, 24), t[0]);
      run_poly(dl[$urandom_range(0, 5)], 0, 0, 1'b1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coef_packer.md
Name: coef_packer

Overview:
- Bit-packing stage directly downstream of the PE array's compress path (CMP_1/4/5/10/11) and of plain 12-bit coefficient output.
- Takes NUM lanes of coefficients per beat and keeps only the low d bits of each.
- Concatenates those bits LSB-first, lane 0 first (FIPS 203 ByteEncode_d order), and emits 32-bit words to the output buffer/memory writer.
- Valid/ready on both sides; an explicit end-of-polynomial flush pads the last partial word with zeros.

Parameters:
- NUM, 4, coefficient lanes per input beat (matches pe_array NUM)
- WIDTH, 32, coefficient lane width
- OUT_W, 32, output word width
- BUF_W, 96, bit-buffer width; must be >= OUT_W + NUM*12

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- d_sel  in  4  bits per coefficient; legal values 1,4,5,10,11,12; sampled only in IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  NUM x WIDTH  coefficient lanes, lane 0 packed first
- in_last  in  1  qualifies the final beat of the polynomial
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  OUT_W  packed word
- out_last  out  1  marks the final word of the polynomial
- busy  out  1  high in RUN or FLUSH
- range_err  out  1  sticky range-violation flag (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, bit buffer=0, cnt=0, d_reg=0, out_valid=0, out_data=0, out_last=0, in_ready=0, busy=0, range_err=0.
- States:
  - IDLE: d_reg<=d_sel; in_ready=1. First accepted beat moves to RUN, or directly to FLUSH if in_last.
  - RUN: accepting and emitting. Accepted beat with in_last -> FLUSH.
  - FLUSH: in_ready=0; drain. After the pop of the word carrying out_last -> IDLE.
- Push: beat accepted when in_valid && in_ready.
  - in_ready = (state!=FLUSH) && (cnt_next_after_pop + NUM*d_reg <= BUF_W). It uses the cnt after any same-cycle pop, so the path is combinational from out_ready.
  - Packed beat: p = concatenation of in_data[k][d_reg-1:0], k = 0..NUM-1, lane k at bit offset k*d_reg. Bits above d_reg are ignored.
- Pop: out_valid = (cnt>=OUT_W) || (state==FLUSH && cnt>0); out_data = buf[OUT_W-1:0].
  - A short flush word is zero-padded above cnt; the buffer never holds stale bits above cnt.
  - out_last = FLUSH && cnt<=OUT_W.
  - On pop: full word, cnt -= OUT_W; final word, cnt = 0.
- Simultaneous push and pop in one cycle: buf <= (buf >> popbits) | (p << (cnt - popbits)); cnt <= cnt - popbits + NUM*d_reg.
- out_data/out_valid hold stable while out_valid && !out_ready.
- Latency: a word becomes valid the cycle after the push that completes it. Sustained throughput is 1 beat/cycle whenever NUM*d_reg <= OUT_W; otherwise the output side limits it.
- Empty flush: in_last on a beat giving cnt==0 cannot occur (NUM*d>0). The FLUSH exit rule still holds for that case.
- d_sel changes outside IDLE are ignored. An illegal d_sel is treated as 12.
- cnt width: clog2(BUF_W+1) bits.

Optional Feature:
- Macro: COEF_PACKER_RANGE_CHK_EN.
- When defined: any accepted lane with in_data[k] >= (1<<d_reg) sets range_err. It is cleared only by reset or by leaving FLUSH to IDLE. Packing is unaffected (truncation still applies).
- When undefined: range_err is tied 0 and the comparators are absent.

Decomposition:
- Shared package pe_pkg holds:
  - pe_instr_t and pe_alg_t;
  - localparams for legal d values (D_1, D_4, D_5, D_10, D_11, D_12);
  - packer state enum pack_state_t {IDLE, RUN, FLUSH}.
- One natural sub-module: coef_lane_merge, the combinational lane concatenator producing p from in_data and d_reg.

Test Plan:
- d=1, 8 beats of lanes {1,0,1,0}, last on beat 8 -> exactly one word 0x55555555 with out_last=1.
- d=12, single beat {0xABC,0x123,0x456,0x789} with in_last -> word0 0x56123ABC (out_last=0), then word1 0x00007894 (out_last=1), then return to IDLE.
- d=10, 64 beats (256 coeffs), random data, out_ready=1 -> 80 words; out_last only on word 80; the bitstream matches the reference ByteEncode_10 model.
- d=11, out_ready held low 10 cycles mid-stream:
  - in_ready deasserts once cnt>52;
  - out_data stays stable;
  - no bits are lost or duplicated after release (stream compared against the model).
- Reset mid-RUN (rst=0 for 1 cycle) -> all outputs 0 immediately. A following fresh polynomial packs correctly.
- With COEF_PACKER_RANGE_CHK_EN, d=4, a lane value 0x1F -> range_err=1 and the packed nibble is 0xF. Without the macro, range_err stays 0.
